// File: rtl/div64x32_seq.sv
// rtl/div64x32_seq.sv - sequential unsigned 64/32 restoring divider, one quotient bit per cycle
module div64x32_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero,
  output logic        overflow
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  // Partial remainder is always < bd, so its 33rd bit is constant zero and not stored.
  logic [31:0] rem;
  logic [31:0] q;
  logic [31:0] bd;
  logic [4:0]  count;
  logic        dz_r;
  logic        ov_r;
  logic [32:0] shifted;
  logic [32:0] trial;

  always_comb begin
    shifted = {rem, q[31]};
    trial   = shifted - {1'b0, bd};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rem         <= '0;
      q           <= '0;
      bd          <= '0;
      count       <= '0;
      dz_r        <= 1'b0;
      ov_r        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            if (b == '0) begin
              dz_r  <= 1'b1;
              ov_r  <= 1'b0;
              q     <= '1;
              rem   <= a[31:0];
              state <= DONE;
            end else if (a[63:32] >= b) begin
              dz_r  <= 1'b0;
              ov_r  <= 1'b1;
              q     <= '1;
              rem   <= '0;
              state <= DONE;
            end else begin
              dz_r  <= 1'b0;
              ov_r  <= 1'b0;
              rem   <= a[63:32];
              q     <= a[31:0];
              bd    <= b;
              count <= '0;
              busy  <= 1'b1;
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (!trial[32]) begin
            rem <= trial[31:0];
            q   <= {q[30:0], 1'b1};
          end else begin
            rem <= shifted[31:0];
            q   <= {q[30:0], 1'b0};
          end
          count <= count + 5'd1;
          if (count == 5'd31) begin
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          quotient    <= q;
          remainder   <= rem;
          div_by_zero <= dz_r;
          overflow    <= ov_r;
          done        <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div64x32_seq.sv
// tb/tb_div64x32_seq.sv - self-checking bench for div64x32_seq against an arithmetic reference
module tb_div64x32_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  div64x32_seq dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit division plus the error rules.
  task automatic model(input logic [63:0] ta, input logic [31:0] tb_v,
                       output logic [31:0] eq, output logic [31:0] er,
                       output logic edz, output logic eov, output int elat);
    logic [63:0] qq;
    logic [63:0] rr;
    if (tb_v == 0) begin
      eq = 32'hFFFF_FFFF; er = ta[31:0]; edz = 1'b1; eov = 1'b0; elat = 1;
    end else if (ta[63:32] >= tb_v) begin
      eq = 32'hFFFF_FFFF; er = 32'h0; edz = 1'b0; eov = 1'b1; elat = 1;
    end else begin
      qq = ta / {32'h0, tb_v};
      rr = ta % {32'h0, tb_v};
      eq = qq[31:0]; er = rr[31:0]; edz = 1'b0; eov = 1'b0; elat = 33;
    end
  endtask

  // Called just after a posedge; the next posedge accepts. Returns just after the done edge.
  task automatic run_op(input logic [63:0] ta, input logic [31:0] tb_v, input int inject_at);
    logic [31:0] eq;
    logic [31:0] er;
    logic        edz;
    logic        eov;
    int          elat;
    int          lat;
    int          busy_cnt;
    model(ta, tb_v, eq, er, edz, eov, elat);
    start = 1'b1; a = ta; b = tb_v;
    @(posedge clk); #1;
    start = 1'b0; a = {$urandom, $urandom}; b = $urandom;
    chk("done_low_after_accept", done, 1'b0);
    chk("dz_cleared_on_accept", div_by_zero, 1'b0);
    chk("ov_cleared_on_accept", overflow, 1'b0);
    lat = 0;
    busy_cnt = busy ? 1 : 0;
    for (int i = 1; i <= 40; i++) begin
      if (i == inject_at) begin
        start = 1'b1; a = 64'd10; b = 32'd1;
      end else if (i == inject_at + 1) begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
      if (busy) busy_cnt++;
    end
    start = 1'b0;
    chk("latency", lat, elat);
    chk("busy_cycles", busy_cnt, (elat == 33) ? 32 : 0);
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    chk("div_by_zero", div_by_zero, edz);
    chk("overflow", overflow, eov);
  endtask

  initial begin
    int done_cnt;
    logic [31:0] rb;
    logic [31:0] rh;
    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_quotient", quotient, 32'h0);
    chk("rst_remainder", remainder, 32'h0);
    chk("rst_dz", div_by_zero, 1'b0);
    chk("rst_ov", overflow, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(64'd100, 32'd7, -1);
    @(posedge clk); #1;
    run_op(64'hFFFF_FFFE_FFFF_FFFF, 32'hFFFF_FFFF, -1);
    @(posedge clk); #1;
    run_op(64'h0000_0001_0000_0000, 32'd2, -1);
    run_op(64'd0, 32'd9, -1);
    run_op(64'h1234_5678_9ABC_DEF0, 32'd0, -1);
    run_op(64'h0000_0005_0000_0000, 32'd5, -1);
    run_op(64'd1000, 32'd3, 5);
    @(posedge clk); #1;

    // Reset mid-RUN discards the operation.
    start = 1'b1; a = 64'd1000; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrun_rst_busy", busy, 1'b0);
    chk("midrun_rst_done", done, 1'b0);
    chk("midrun_rst_quotient", quotient, 32'h0);
    chk("midrun_rst_remainder", remainder, 32'h0);
    chk("midrun_rst_flags", {div_by_zero, overflow}, 2'b00);
    done_cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    chk("midrun_rst_no_done", done_cnt, 0);

    // Start and reset on the same edge: reset wins.
    start = 1'b1; reset = 1'b1; a = 64'd50; b = 32'd0;
    @(posedge clk); #1;
    start = 1'b0; reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("start_with_reset_dz", div_by_zero, 1'b0);
    chk("start_with_reset_quotient", quotient, 32'h0);

    run_op(64'd1000, 32'd3, -1);

    for (int n = 0; n < 20; n++) begin
      int mode;
      mode = $urandom_range(0, 9);
      rb = $urandom;
      if (mode == 0) rb = 32'h0;
      if (rb == 0 && mode != 0) rb = 32'd1;
      if (mode == 0) rh = $urandom;
      else if (mode == 1) rh = rb + 32'($urandom_range(0, 3));
      else rh = $urandom % rb;
      if (mode == 1 && rh < rb) rh = rb;
      run_op({rh, 32'($urandom)}, rb, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
